// File: rtl/pixel_stream_feeder.sv
// Frame buffer that loads one binary-pixel frame in raster order and serves it,
// one pixel per request, to the convolution processing unit.
module pixel_stream_feeder #(
  parameter int BIN_LEN       = 8,
  parameter int INPUT_WIDTH   = 2,
  parameter int INPUT_HEIGHT  = 2,
  parameter int PIX_COUNT_LOG = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     load_valid,
  input  logic [BIN_LEN-1:0]       load_data,
  output logic                     load_ready,
  output logic                     pu_start,
  input  logic                     input_req,
  output logic [BIN_LEN-1:0]       input_val,
  output logic                     input_ready,
  input  logic                     pu_done,
  output logic                     frame_done,
  output logic [PIX_COUNT_LOG-1:0] served_count,
  output logic                     protocol_err
);

  localparam int N = INPUT_WIDTH * INPUT_HEIGHT;
  localparam logic [PIX_COUNT_LOG-1:0] LAST = PIX_COUNT_LOG'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    SERVE_WAIT,
    SERVE_ACK,
    SERVE_HOLD,
    DRAIN,
    FRAME_DONE
  } state_t;

  state_t                   state;
  logic [PIX_COUNT_LOG-1:0] wr_ptr;
  logic [PIX_COUNT_LOG-1:0] rd_ptr;
  logic [BIN_LEN-1:0]       mem [2**PIX_COUNT_LOG];
  logic                     wr_en;

  // Writes are only taken while loading; load_valid elsewhere is dropped.
  assign wr_en = (state == LOAD) && load_valid && load_ready;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      input_val    <= '0;
      input_ready  <= 1'b0;
      pu_start     <= 1'b0;
      load_ready   <= 1'b0;
      frame_done   <= 1'b0;
      served_count <= '0;
      protocol_err <= 1'b0;
    end else begin
      pu_start    <= 1'b0;
      input_ready <= 1'b0;

      case (state)
        IDLE, FRAME_DONE: begin
          if (frame_start) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
            load_ready   <= 1'b1;
          end
        end

        LOAD: begin
          if (load_valid && load_ready) begin
            wr_ptr <= wr_ptr + PIX_COUNT_LOG'(1);
            if (wr_ptr == LAST) begin
              state      <= ARM;
              load_ready <= 1'b0;
              pu_start   <= 1'b1;
            end
          end
        end

        ARM: begin
          rd_ptr       <= '0;
          served_count <= '0;
          state        <= SERVE_WAIT;
        end

        SERVE_WAIT: begin
          if (input_req) begin
            input_val   <= mem[rd_ptr];
            input_ready <= 1'b1;
            state       <= SERVE_ACK;
          end
        end

        SERVE_ACK: begin
          rd_ptr       <= rd_ptr + PIX_COUNT_LOG'(1);
          served_count <= served_count + PIX_COUNT_LOG'(1);
          state        <= (rd_ptr == LAST) ? DRAIN : SERVE_HOLD;
        end

        // The unit keeps req high through the ack cycle; wait for it to drop
        // so one request never yields two pixels.
        SERVE_HOLD: begin
          if (!input_req) state <= SERVE_WAIT;
        end

        DRAIN: begin
          if (input_req) protocol_err <= 1'b1;
          if (pu_done) begin
            state      <= FRAME_DONE;
            frame_done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      if (pu_done && (state != DRAIN) && (state != FRAME_DONE)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Directed bench for pixel_stream_feeder on a 2x2 frame: a cycle-by-cycle
// vector table followed by request-model, reset-abort and reload sequences.
module tb_pixel_stream_feeder;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       pu_start;
  logic       input_req;
  logic [7:0] input_val;
  logic       input_ready;
  logic       pu_done;
  logic       frame_done;
  logic [2:0] served_count;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;

  pixel_stream_feeder #(
    .BIN_LEN(8), .INPUT_WIDTH(2), .INPUT_HEIGHT(2), .PIX_COUNT_LOG(3)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .pu_start(pu_start), .input_req(input_req), .input_val(input_val),
    .input_ready(input_ready), .pu_done(pu_done), .frame_done(frame_done),
    .served_count(served_count), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fs;
    logic       lv;
    logic [7:0] ld;
    logic       req;
    logic       done;
    logic       lr;
    logic       ps;
    logic       ir;
    logic [7:0] iv;
    logic [2:0] sc;
    logic       fd;
    logic       pe;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lr"}, 32'(load_ready), 0);
    chk({tag, "_ps"}, 32'(pu_start), 0);
    chk({tag, "_ir"}, 32'(input_ready), 0);
    chk({tag, "_iv"}, 32'(input_val), 0);
    chk({tag, "_sc"}, 32'(served_count), 0);
    chk({tag, "_fd"}, 32'(frame_done), 0);
    chk({tag, "_pe"}, 32'(protocol_err), 0);
  endtask

  task automatic load_frame(input logic [31:0] pix, input string tag);
    int pulses;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk({tag, "_load_ready_up"}, 32'(load_ready), 1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = pix[31-8*i -: 8];
      @(negedge clock);
      if (i < 3) chk($sformatf("%s_load_ready_w%0d", tag, i), 32'(load_ready), 1);
    end
    load_valid = 1'b0;
    chk({tag, "_load_ready_drop"}, 32'(load_ready), 0);
    pulses = 0;
    repeat (4) begin
      if (pu_start) pulses++;
      @(negedge clock);
    end
    chk({tag, "_pu_start_width"}, 32'(pulses), 1);
    $display("load %s pixels=%08h pu_start_cycles=%0d", tag, pix, pulses);
  endtask

  task automatic serve_one(input logic [7:0] exp, input int hold, input int low, input string tag);
    int lat;
    int extra;
    input_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!input_ready && lat < 8);
    chk({tag, "_latency"}, 32'(lat), 1);
    chk({tag, "_val"}, 32'(input_val), 32'(exp));
    extra = 0;
    repeat (hold) begin
      @(negedge clock);
      if (input_ready) extra++;
    end
    input_req = 1'b0;
    repeat (low) begin
      @(negedge clock);
      if (input_ready) extra++;
    end
    chk({tag, "_extra_ready"}, 32'(extra), 0);
    $display("serve %s val=%02h latency=%0d extra=%0d", tag, input_val, lat, extra);
  endtask

  initial begin
    //         fs lv ld     req done lr ps ir iv     sc    fd pe
    vecs[0]  = '{0, 1, 8'hAA, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[1]  = '{1, 1, 8'hAA, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[2]  = '{0, 1, 8'h11, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[3]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[4]  = '{0, 1, 8'h22, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[5]  = '{0, 1, 8'h33, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[6]  = '{0, 1, 8'h44, 0, 0, 0, 1, 0, 8'h00, 3'd0, 0, 0};
    vecs[7]  = '{0, 1, 8'h55, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0};
    vecs[9]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h11, 3'd0, 0, 0};
    vecs[10] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h11, 3'd1, 0, 0};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h11, 3'd1, 0, 0};
    vecs[12] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h11, 3'd1, 0, 0};
    vecs[13] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h11, 3'd1, 0, 0};
    vecs[14] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h22, 3'd1, 0, 0};
    vecs[15] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h22, 3'd2, 0, 0};
    vecs[16] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h22, 3'd2, 0, 0};
    vecs[17] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h33, 3'd2, 0, 0};
    vecs[18] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h33, 3'd3, 0, 0};
    vecs[19] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h33, 3'd3, 0, 0};
    vecs[20] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h44, 3'd3, 0, 0};
    vecs[21] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h44, 3'd4, 0, 0};
    vecs[22] = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h44, 3'd4, 0, 1};
    vecs[23] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h44, 3'd4, 1, 1};
    vecs[24] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h44, 3'd4, 1, 1};
    vecs[25] = '{1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h44, 3'd4, 0, 0};
    vecs[26] = '{0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h44, 3'd4, 0, 1};

    reset = 1'b1;
    frame_start = 1'b0;
    load_valid = 1'b0;
    load_data = 8'h00;
    input_req = 1'b0;
    pu_done = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset_held");
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("reset_released");

    for (int i = 0; i < 27; i++) begin
      frame_start = vecs[i].fs;
      load_valid  = vecs[i].lv;
      load_data   = vecs[i].ld;
      input_req   = vecs[i].req;
      pu_done     = vecs[i].done;
      @(negedge clock);
      chk($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(vecs[i].lr));
      chk($sformatf("v%0d_pu_start", i), 32'(pu_start), 32'(vecs[i].ps));
      chk($sformatf("v%0d_input_ready", i), 32'(input_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d_input_val", i), 32'(input_val), 32'(vecs[i].iv));
      chk($sformatf("v%0d_served_count", i), 32'(served_count), 32'(vecs[i].sc));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      chk($sformatf("v%0d_protocol_err", i), 32'(protocol_err), 32'(vecs[i].pe));
      $display("vec %0d ir=%0b iv=%02h sc=%0d fd=%0b pe=%0b", i, input_ready, input_val,
               served_count, frame_done, protocol_err);
    end
    frame_start = 1'b0;
    load_valid = 1'b0;
    input_req = 1'b0;
    pu_done = 1'b0;

    // Frame B: request model with 20 idle cycles between requests.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    load_frame(32'h5A6B7C8D, "B");
    serve_one(8'h5A, 1, 20, "B0");
    serve_one(8'h6B, 1, 20, "B1");
    serve_one(8'h7C, 1, 20, "B2");
    serve_one(8'h8D, 1, 20, "B3");
    chk("B_served_count", 32'(served_count), 4);
    chk("B_protocol_err", 32'(protocol_err), 0);
    chk("B_frame_done_early", 32'(frame_done), 0);
    pu_done = 1'b1;
    @(negedge clock);
    pu_done = 1'b0;
    chk("B_frame_done", 32'(frame_done), 1);
    chk("B_last_val_held", 32'(input_val), 32'h8D);

    // Frame C: long request hold, then reset aborts mid-serve.
    load_frame(32'h01020304, "C");
    chk("C_frame_done_clear", 32'(frame_done), 0);
    serve_one(8'h01, 3, 2, "C0");
    serve_one(8'h02, 3, 2, "C1");
    chk("C_protocol_err", 32'(protocol_err), 0);
    chk("C_served_count", 32'(served_count), 2);
    input_req = 1'b1;
    @(negedge clock);
    chk("C_third_ready", 32'(input_ready), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clock);
    input_req = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("post_abort");

    // Frame D: reload after the abort starts again from pixel 0.
    load_frame(32'hF0E1D2C3, "D");
    serve_one(8'hF0, 1, 2, "D0");
    chk("D_served_count", 32'(served_count), 1);
    chk("D_protocol_err", 32'(protocol_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
